// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan/direct line decoder.
package scan_decoder_pkg;

   localparam int unsigned MAX_SEL_W = 6;
   localparam int unsigned MAX_OUT_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_e;

   // Number of decoded lines for a given select width.
   function automatic int unsigned out_w(input int unsigned sel_w);
      return 32'(1) << sel_w;
   endfunction

   // Full-width one-hot pattern; callers truncate to their own OUT_W.
   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx,
                                                   input logic active_low);
      logic [MAX_OUT_W-1:0] v;
      v = MAX_OUT_W'(1) << idx;
      return active_low ? ~v : v;
   endfunction

endpackage

// File: rtl/scan_decoder_timer.sv
// Loadable down-counter holding the scan index on a line for dwell+1 cycles.
module dwell_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         expired_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // expired tracks cnt==0 as a register, updated alongside the count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         expired_q <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= (cnt_d == '0);
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/scan_decoder.sv
// N-to-2^N decoder with direct and dwell-timed scan modes, registered outputs.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned ACTIVE_LOW = 1,
   parameter int unsigned DWELL_W    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en_n,
   input  logic                    mode,
   input  logic                    start,
   input  logic [SEL_W-1:0]        sel,
   input  logic [DWELL_W-1:0]      dwell,
   output logic [(2**SEL_W)-1:0]   d_out,
   output logic [SEL_W-1:0]        idx,
   output logic                    busy,
   output logic                    wrap
);

   localparam int unsigned          OUT_W    = out_w(SEL_W);
   localparam logic                 AL       = (ACTIVE_LOW != 0);
   localparam logic [OUT_W-1:0]     INACTIVE = {OUT_W{AL}};
   localparam logic [SEL_W-1:0]     LAST_IDX = SEL_W'(OUT_W - 1);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  idx_q, idx_d;
   logic [OUT_W-1:0]  d_out_q, d_out_d;
   logic              busy_q, busy_d;
   logic              wrap_q, wrap_d;
   logic              tmr_load, tmr_dec, tmr_expired;

   function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
      return OUT_W'(onehot(MAX_SEL_W'(i), AL));
   endfunction

   dwell_timer #(
      .W (DWELL_W)
   ) u_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (tmr_load),
      .load_val_i (dwell),
      .dec_i      (tmr_dec),
      .expired_o  (tmr_expired)
   );

   // Priority: en_n > direct mode > start > scan advance.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      d_out_d  = d_out_q;
      busy_d   = 1'b0;
      wrap_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;

      if (en_n) begin
         state_d = ST_IDLE;
         d_out_d = INACTIVE;
      end else if (!mode) begin
         state_d = ST_DIRECT;
         idx_d   = sel;
         d_out_d = decode(sel);
      end else if (start) begin
         state_d  = ST_SCAN;
         idx_d    = sel;
         d_out_d  = decode(sel);
         busy_d   = 1'b1;
         tmr_load = 1'b1;
      end else if (state_q == ST_SCAN) begin
         busy_d = 1'b1;
         if (tmr_expired) begin
            idx_d    = idx_q + SEL_W'(1);
            tmr_load = 1'b1;
            wrap_d   = (idx_q == LAST_IDX);
         end else begin
            tmr_dec = 1'b1;
         end
         d_out_d = decode(idx_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         d_out_q <= INACTIVE;
         busy_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         d_out_q <= d_out_d;
         busy_q  <= busy_d;
         wrap_q  <= wrap_d;
      end
   end

   assign d_out = d_out_q;
   assign idx   = idx_q;
   assign busy  = busy_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench: 4-line active-low instance and 8-line active-high instance.
module tb_scan_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_n_a, mode_a, start_a;
   logic [1:0] sel_a;
   logic [3:0] dwell_a;
   logic [3:0] d_out_a;
   logic [1:0] idx_a;
   logic       busy_a, wrap_a;

   logic       rst_b, en_n_b, mode_b, start_b;
   logic [2:0] sel_b;
   logic [3:0] dwell_b;
   logic [7:0] d_out_b;
   logic [2:0] idx_b;
   logic       busy_b, wrap_b;

   scan_decoder #(.SEL_W(2), .ACTIVE_LOW(1), .DWELL_W(4)) dut_a (
      .clk(clk), .rst(rst_a), .en_n(en_n_a), .mode(mode_a), .start(start_a),
      .sel(sel_a), .dwell(dwell_a), .d_out(d_out_a), .idx(idx_a),
      .busy(busy_a), .wrap(wrap_a));

   scan_decoder #(.SEL_W(3), .ACTIVE_LOW(0), .DWELL_W(4)) dut_b (
      .clk(clk), .rst(rst_b), .en_n(en_n_b), .mode(mode_b), .start(start_b),
      .sel(sel_b), .dwell(dwell_b), .d_out(d_out_b), .idx(idx_b),
      .busy(busy_b), .wrap(wrap_b));

   typedef struct {
      logic [7:0] dout;
      int         idx;
      bit         busy;
      bit         wrap;
   } exp_t;

   exp_t sb_q[$];

   int         m_ow[2];
   bit         m_al[2];
   int         m_st[2];
   int         m_idx[2];
   int         m_cnt[2];
   logic [7:0] m_dout[2];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] line(input int i, input int k);
      logic [7:0] v;
      logic [7:0] mask;
      v    = 8'(1) << k;
      mask = 8'((1 << m_ow[i]) - 1);
      if (m_al[i]) v = ~v;
      return v & mask;
   endfunction

   function automatic logic [7:0] inactive(input int i);
      return m_al[i] ? 8'((1 << m_ow[i]) - 1) : 8'h00;
   endfunction

   // Reference behaviour, one clock per call; states 0 idle, 1 direct, 2 scan.
   task automatic model_step(input int i, input bit r, input bit e_n, input bit md,
                             input bit st, input int s, input int dw, output exp_t e);
      bit w;
      bit b;
      w = 1'b0;
      b = 1'b0;
      if (r) begin
         m_st[i] = 0; m_idx[i] = 0; m_cnt[i] = 0; m_dout[i] = inactive(i);
      end else if (e_n) begin
         m_st[i] = 0; m_dout[i] = inactive(i);
      end else if (!md) begin
         m_st[i] = 1; m_idx[i] = s; m_dout[i] = line(i, s);
      end else if (st) begin
         m_st[i] = 2; m_idx[i] = s; m_cnt[i] = dw; m_dout[i] = line(i, s); b = 1'b1;
      end else if (m_st[i] == 2) begin
         b = 1'b1;
         if (m_cnt[i] == 0) begin
            w = (m_idx[i] == m_ow[i] - 1);
            m_idx[i] = (m_idx[i] + 1) % m_ow[i];
            m_cnt[i] = dw;
         end else begin
            m_cnt[i] = m_cnt[i] - 1;
         end
         m_dout[i] = line(i, m_idx[i]);
      end
      e.dout = m_dout[i];
      e.idx  = m_idx[i];
      e.busy = b;
      e.wrap = w;
   endtask

   task automatic cycle();
      exp_t e;
      model_step(0, rst_a, en_n_a, mode_a, start_a, int'(sel_a), int'(dwell_a), e);
      sb_q.push_back(e);
      model_step(1, rst_b, en_n_b, mode_b, start_b, int'(sel_b), int'(dwell_b), e);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("a_dout", 64'(d_out_a), 64'(e.dout[3:0]));
      check("a_idx",  64'(idx_a),   64'(e.idx));
      check("a_busy", 64'(busy_a),  64'(e.busy));
      check("a_wrap", 64'(wrap_a),  64'(e.wrap));
      check("a_onehot", 64'($countones(d_out_a ^ 4'hF) <= 1), 64'(1));
      e = sb_q.pop_front();
      check("b_dout", 64'(d_out_b), 64'(e.dout));
      check("b_idx",  64'(idx_b),   64'(e.idx));
      check("b_busy", 64'(busy_b),  64'(e.busy));
      check("b_wrap", 64'(wrap_b),  64'(e.wrap));
      check("b_onehot", 64'($countones(d_out_b) <= 1), 64'(1));
   endtask

   initial begin
      int         seq_a[8];
      logic [7:0] one;
      seq_a = '{2, 3, 3, 0, 0, 1, 1, 2};
      one   = 8'd1;

      m_ow[0] = 4; m_al[0] = 1'b1;
      m_ow[1] = 8; m_al[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_idx[i] = 0; m_cnt[i] = 0; m_dout[i] = inactive(i);
      end

      rst_a = 1'b1; en_n_a = 1'b0; mode_a = 1'b0; start_a = 1'b0; sel_a = 2'd2; dwell_a = 4'd0;
      rst_b = 1'b1; en_n_b = 1'b0; mode_b = 1'b0; start_b = 1'b0; sel_b = 3'd0; dwell_b = 4'd0;

      // Reset holds outputs inactive despite a direct select.
      cycle(); cycle();
      check("rst_dout", 64'(d_out_a), 64'(4'b1111));
      check("rst_busy", 64'(busy_a), 64'(0));
      rst_a = 1'b0;
      cycle();
      check("rel_dout", 64'(d_out_a), 64'(4'b1011));
      check("rel_idx",  64'(idx_a), 64'(2));

      sel_a = 2'd0; cycle(); check("dir0", 64'(d_out_a), 64'(4'b1110));
      sel_a = 2'd1; cycle(); check("dir1", 64'(d_out_a), 64'(4'b1101));
      sel_a = 2'd3; cycle(); check("dir3", 64'(d_out_a), 64'(4'b0111));
      en_n_a = 1'b1; cycle(); check("en_off", 64'(d_out_a), 64'(4'b1111));
      check("en_idx_hold", 64'(idx_a), 64'(3));

      // Scan with dwell 1 from line 2.
      en_n_a = 1'b0; mode_a = 1'b1; dwell_a = 4'd1; sel_a = 2'd2; start_a = 1'b1;
      cycle();
      check("scan_start_idx", 64'(idx_a), 64'(2));
      check("scan_busy", 64'(busy_a), 64'(1));
      start_a = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("scan_idx", 64'(idx_a), 64'(seq_a[k]));
         check("scan_wrap", 64'(wrap_a), 64'(k == 3));
      end

      sel_a = 2'd1; start_a = 1'b1; cycle();
      check("restart_idx", 64'(idx_a), 64'(1));
      check("restart_wrap", 64'(wrap_a), 64'(0));
      start_a = 1'b0; cycle(); cycle(); cycle();
      mode_a = 1'b0; sel_a = 2'd3; cycle();
      check("abort_busy", 64'(busy_a), 64'(0));
      check("abort_dout", 64'(d_out_a), 64'(4'b0111));

      // Reset mid-scan at line 3.
      mode_a = 1'b1; sel_a = 2'd3; dwell_a = 4'd2; start_a = 1'b1; cycle();
      start_a = 1'b0; cycle();
      check("pre_rst_idx", 64'(idx_a), 64'(3));
      rst_a = 1'b1; cycle();
      check("mrst_dout", 64'(d_out_a), 64'(4'b1111));
      check("mrst_idx",  64'(idx_a), 64'(0));
      check("mrst_busy", 64'(busy_a), 64'(0));
      rst_a = 1'b0; mode_a = 1'b0; cycle();

      // Active-high 8-line scan, one cycle per line.
      rst_b = 1'b0; mode_b = 1'b1; dwell_b = 4'd0; sel_b = 3'd0; start_b = 1'b1;
      cycle();
      check("b_start", 64'(d_out_b), 64'(8'h01));
      start_b = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         cycle();
         check("b_shift", 64'(d_out_b), 64'(one << (k % 8)));
         check("b_wrap8", 64'(wrap_b), 64'((k % 8) == 0));
      end

      // Random traffic on both instances.
      for (int n = 0; n < 400; n++) begin
         rst_a   = ($urandom_range(0, 59) == 0);
         en_n_a  = ($urandom_range(0, 9) == 0);
         mode_a  = ($urandom_range(0, 7) != 0);
         start_a = ($urandom_range(0, 11) == 0);
         sel_a   = 2'($urandom_range(0, 3));
         dwell_a = 4'($urandom_range(0, 3));
         rst_b   = ($urandom_range(0, 59) == 0);
         en_n_b  = ($urandom_range(0, 9) == 0);
         mode_b  = ($urandom_range(0, 7) != 0);
         start_b = ($urandom_range(0, 11) == 0);
         sel_b   = 3'($urandom_range(0, 7));
         dwell_b = 4'($urandom_range(0, 3));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
